// File: rtl/board_eval.sv
// board_eval: reads an array of 64-word boards over the Avalon master, scores material per board
// from the side to move, and holds the best board index/score for the CPU on the Avalon slave.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | registers writable, result readable, waiting for start
// ST_RD_REQ  | master_read held with square address until waitrequest drops
// ST_RD_WAIT | waiting for readdatavalid, accumulate piece value
// ST_CMP     | apply colour sign, update best, advance to next board
module board_eval (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_CMP     = 2'd3;

    logic [1:0]         r_state;
    logic [31:0]        r_src;
    logic [7:0]         r_num_boards;
    logic               r_white;
    logic [7:0]         r_board;
    logic [5:0]         r_sq;
    logic signed [15:0] r_acc;
    logic [31:0]        r_best_idx;
    logic signed [15:0] r_best_score;

    logic [7:0]         w_code;
    logic [7:0]         w_mag;
    logic signed [15:0] w_piece;
    logic signed [15:0] w_acc_next;
    logic signed [15:0] w_score;
    logic               w_unused;

    // Only the low byte of a square carries the piece code; slave_read needs no qualification
    // because readdata is a pure function of the address.
    assign w_unused = ^{slave_read, master_readdata[31:8]};

    assign w_code = master_readdata[7:0];
    assign w_mag  = w_code[7] ? (~w_code + 8'd1) : w_code;

    always_comb begin
        w_piece = 16'sd0;
        case (w_mag)
            8'd1:    w_piece = 16'sd1;
            8'd2:    w_piece = 16'sd3;
            8'd3:    w_piece = 16'sd3;
            8'd4:    w_piece = 16'sd5;
            8'd5:    w_piece = 16'sd9;
            default: w_piece = 16'sd0;
        endcase
    end

    assign w_acc_next = w_code[7] ? (r_acc - w_piece) : (r_acc + w_piece);
    assign w_score    = r_white ? r_acc : -r_acc;

    assign slave_waitrequest = rst | (r_state != ST_IDLE);
    assign master_read       = (r_state == ST_RD_REQ);
    assign master_address    = (r_state == ST_RD_REQ) ? (r_src + {18'd0, r_board, r_sq}) : 32'd0;
    assign master_write      = 1'b0;
    assign master_writedata  = 32'd0;

    always_comb begin
        slave_readdata = 32'd0;
        case (slave_address)
            4'd0:    slave_readdata = r_best_idx;
            4'd4:    slave_readdata = {{16{r_best_score[15]}}, r_best_score};
            default: slave_readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_src        <= 32'd0;
            r_num_boards <= 8'd0;
            r_white      <= 1'b0;
            r_board      <= 8'd0;
            r_sq         <= 6'd0;
            r_acc        <= 16'sd0;
            r_best_idx   <= 32'd0;
            r_best_score <= 16'sd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (slave_write) begin
                        case (slave_address)
                            4'd0: begin
                                r_board <= 8'd0;
                                r_sq    <= 6'd0;
                                r_acc   <= 16'sd0;
                                if (r_num_boards == 8'd0) begin
                                    r_best_idx   <= 32'hFFFF_FFFF;
                                    r_best_score <= 16'sd0;
                                end else begin
                                    r_best_idx   <= 32'd0;
                                    r_best_score <= 16'h8000;
                                    r_state      <= ST_RD_REQ;
                                end
                            end
                            4'd1:    r_src        <= slave_writedata;
                            4'd2:    r_num_boards <= slave_writedata[7:0];
                            4'd3:    r_white      <= (slave_writedata == 32'd1);
                            default: ;
                        endcase
                    end
                end
                ST_RD_REQ: begin
                    if (!master_waitrequest) begin
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        r_acc <= w_acc_next;
                        if (r_sq == 6'd63) begin
                            r_state <= ST_CMP;
                        end else begin
                            r_sq    <= r_sq + 6'd1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_CMP: begin
                    // Strictly greater keeps the lowest index on ties.
                    if (w_score > r_best_score) begin
                        r_best_score <= w_score;
                        r_best_idx   <= {24'd0, r_board};
                    end
                    r_acc <= 16'sd0;
                    r_sq  <= 6'd0;
                    if (r_board == (r_num_boards - 8'd1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_board <= r_board + 8'd1;
                        r_state <= ST_RD_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: SDRAM responder with programmable wait/latency plus
// a linear sequence of CPU runs with hand-computed best index/score and cycle counts.
module tb_board_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    board_eval dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [0:4095];
    int          wait_n = 0;
    int          lat_n = 0;
    int          acc_cnt = 0;
    int          rd_cycles = 0;
    logic [31:0] exp_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SDRAM responder: decisions made on the falling edge so the DUT sees them at the next rise.
    initial begin : sdram
        logic        pend;
        int          pdly;
        int          wcnt;
        logic        stalled;
        logic [31:0] paddr;
        logic [31:0] held;
        pend = 1'b0; pdly = 0; wcnt = 0; stalled = 1'b0; paddr = 32'd0; held = 32'd0;
        master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata = 32'd0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            if (rst) begin
                pend = 1'b0; wcnt = 0; stalled = 1'b0;
                master_waitrequest = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_rd", {31'd0, master_read}, 32'd1);
                    check("hold_addr", master_address, held);
                end
                stalled = 1'b0;
                if (pend) begin
                    if (pdly == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata = mem[paddr[11:0]];
                        pend = 1'b0;
                    end else begin
                        pdly--;
                    end
                end
                if (master_read) begin
                    rd_cycles++;
                    check("one_outstanding", {31'd0, pend}, 32'd0);
                    if (wcnt < wait_n) begin
                        master_waitrequest = 1'b1;
                        wcnt++;
                        stalled = 1'b1;
                        held = master_address;
                    end else begin
                        master_waitrequest = 1'b0;
                        wcnt = 0;
                        pend = 1'b1;
                        pdly = lat_n;
                        paddr = master_address;
                        acc_cnt++;
                        check("rd_addr", master_address, exp_addr);
                        exp_addr = exp_addr + 32'd1;
                    end
                end else begin
                    master_waitrequest = 1'b0;
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        #1;
        while (slave_waitrequest && n < 5000) begin
            @(negedge clk); #1; n++;
        end
        check("wr_accept", {31'd0, slave_waitrequest}, 32'd0);
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int stall);
        stall = 0;
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        #1;
        while (slave_waitrequest && stall < 5000) begin
            @(negedge clk); #1; stall++;
        end
        check("rd_accept", {31'd0, slave_waitrequest}, 32'd0);
        d = slave_readdata;
        @(posedge clk); #1;
        slave_read = 1'b0;
    endtask

    // Configures, starts, and reads index (stalling until done) then score.
    task automatic run(input logic [31:0] src, input logic [31:0] nb, input logic [31:0] col,
                       output logic [31:0] idx, output logic [31:0] score, output int stall);
        int s2;
        cpu_write(4'd1, src);
        cpu_write(4'd2, nb);
        cpu_write(4'd3, col);
        exp_addr = src;
        acc_cnt = 0;
        cpu_write(4'd0, 32'd0);
        cpu_read(4'd0, idx, stall);
        cpu_read(4'd4, score, s2);
        check("score_no_stall", s2, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] idx;
        logic [31:0] score;
        logic [31:0] d;
        int          st;
        int          n;
        int          rc;
        rst = 1'b1;
        slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        // board @0x100: queen +9, rook -5 -> +4 white
        mem[12'h105] = 32'h1234_5605;
        mem[12'h120] = 32'hFFFF_FFFC;
        // boards @0x200: +3, -5, -1 from white's view
        mem[12'h203] = 32'h02; mem[12'h210] = 32'h06; mem[12'h211] = 32'hFA;
        mem[12'h212] = 32'h07; mem[12'h213] = 32'h64;
        mem[12'h240] = 32'hFC; mem[12'h241] = 32'h03; mem[12'h27F] = 32'hFD;
        mem[12'h280] = 32'h01; mem[12'h2A0] = 32'h01; mem[12'h2BF] = 32'hFE; mem[12'h290] = 32'h80;
        // boards @0x300: both +1
        mem[12'h300] = 32'h01;
        mem[12'h341] = 32'h01; mem[12'h342] = 32'h05; mem[12'h343] = 32'hFB;

        repeat (3) @(negedge clk);
        #1;
        check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd1);
        check("rst_mread", {31'd0, master_read}, 32'd0);
        check("rst_mwrite", {31'd0, master_write}, 32'd0);
        check("rst_maddr", master_address, 32'd0);
        check("rst_mwdata", master_writedata, 32'd0);
        check("rst_rd0", slave_readdata, 32'd0);
        slave_address = 4'd4; #1;
        check("rst_rd4", slave_readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_waitreq", {31'd0, slave_waitrequest}, 32'd0);

        // single board, white
        run(32'h100, 32'd1, 32'd1, idx, score, st);
        check("t1_idx", idx, 32'd0);
        check("t1_score", score, 32'd4);
        check("t1_cycles", st, 32'd129);
        check("t1_reads", acc_cnt, 32'd64);
        cpu_read(4'd5, d, st);
        check("t1_rd5", d, 32'd0);
        cpu_read(4'd2, d, st);
        check("t1_rd2", d, 32'd0);

        // three boards, black
        run(32'h200, 32'd3, 32'hFFFF_FFFF, idx, score, st);
        check("t2_idx", idx, 32'd1);
        check("t2_score", score, 32'd5);
        check("t2_cycles", st, 32'd387);
        check("t2_reads", acc_cnt, 32'd192);

        // tie keeps lowest index
        run(32'h300, 32'd2, 32'd1, idx, score, st);
        check("tie_idx", idx, 32'd0);
        check("tie_score", score, 32'd1);
        check("tie_cycles", st, 32'd258);

        // colour value 2 means black: negative best, sign-extended
        run(32'h100, 32'd1, 32'd2, idx, score, st);
        check("neg_idx", idx, 32'd0);
        check("neg_score", score, 32'hFFFF_FFFC);

        // zero boards
        rc = rd_cycles;
        run(32'h100, 32'd0, 32'd1, idx, score, st);
        check("zero_idx", idx, 32'hFFFF_FFFF);
        check("zero_score", score, 32'd0);
        check("zero_cycles", st, 32'd0);
        check("zero_no_read", rd_cycles - rc, 32'd0);

        // backpressure: 3 wait cycles per request, valid 2 cycles late
        wait_n = 3; lat_n = 2;
        run(32'h200, 32'd3, 32'hFFFF_FFFF, idx, score, st);
        check("bp_idx", idx, 32'd1);
        check("bp_score", score, 32'd5);
        check("bp_cycles", st, 32'd1347);
        check("bp_reads", acc_cnt, 32'd192);
        wait_n = 0; lat_n = 0;

        // reset during board 1, square 20
        cpu_write(4'd1, 32'h200);
        cpu_write(4'd2, 32'd3);
        cpu_write(4'd3, 32'hFFFF_FFFF);
        exp_addr = 32'h200;
        cpu_write(4'd0, 32'd0);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(master_read && master_address == 32'h254) && n < 2000);
        check("mid_reach_sq20", {31'd0, (master_read && master_address == 32'h254)}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_mread", {31'd0, master_read}, 32'd0);
        check("mid_maddr", master_address, 32'd0);
        check("mid_waitreq", {31'd0, slave_waitrequest}, 32'd1);
        slave_address = 4'd4; #1;
        check("mid_rd4", slave_readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_idle", {31'd0, slave_waitrequest}, 32'd0);
        rc = rd_cycles;
        repeat (5) @(negedge clk);
        check("mid_no_read", rd_cycles - rc, 32'd0);
        // num_boards was reset, so a bare start takes the empty path
        cpu_write(4'd0, 32'd0);
        cpu_read(4'd0, d, st);
        check("mid_numb_reset", d, 32'hFFFF_FFFF);
        run(32'h200, 32'd3, 32'hFFFF_FFFF, idx, score, st);
        check("post_idx", idx, 32'd1);
        check("post_score", score, 32'd5);
        check("post_cycles", st, 32'd387);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
